// File: rtl/sm_alu_mdu_pkg.sv
// sm_alu_mdu_pkg
//  Shared definitions for the schoolMIPS ALU with multiply/divide unit.
//  Holds the 5-bit ALU operation codes, the multiply/divide FSM state
//  type and a helper that classifies operations touching HI/LO.
//  The original single-cycle codes ALU_ADD..ALU_SUBU keep their values.
//  The signed codes ALU_MULT/ALU_DIV always exist here; whether they do
//  anything is decided in sm_alu_mdu by the SM_MDU_SIGNED_EN macro.
package sm_alu_mdu_pkg;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_OR    = 5'd1;
    localparam logic [4:0] ALU_LUI   = 5'd2;
    localparam logic [4:0] ALU_SRL   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_SUBU  = 5'd5;
    localparam logic [4:0] ALU_SLL   = 5'd6;
    localparam logic [4:0] ALU_AND   = 5'd7;
    localparam logic [4:0] ALU_XOR   = 5'd8;
    localparam logic [4:0] ALU_NOR   = 5'd9;
    localparam logic [4:0] ALU_MFHI  = 5'd10;
    localparam logic [4:0] ALU_MFLO  = 5'd11;
    localparam logic [4:0] ALU_MTHI  = 5'd12;
    localparam logic [4:0] ALU_MTLO  = 5'd13;
    localparam logic [4:0] ALU_MULTU = 5'd14;
    localparam logic [4:0] ALU_DIVU  = 5'd15;
    localparam logic [4:0] ALU_MULT  = 5'd16;
    localparam logic [4:0] ALU_DIV   = 5'd17;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mduState_t;

    // True for every operation that reads or writes HI/LO. The signed
    // multiply/divide codes only count when the signed engine is built in,
    // otherwise they behave like any other unknown code.
    function automatic logic isHiLoOp(input logic [4:0] op, input logic signedEn);
        logic hiLo;
        hiLo = (op == ALU_MFHI) || (op == ALU_MFLO) || (op == ALU_MTHI) ||
               (op == ALU_MTLO) || (op == ALU_MULTU) || (op == ALU_DIVU);
        if (signedEn && ((op == ALU_MULT) || (op == ALU_DIV))) begin
            hiLo = 1'b1;
        end
        return hiLo;
    endfunction

endpackage

// File: rtl/sm_alu_mdu_core.sv
// sm_alu_mdu_core
//  Iterative multiply/divide engine with the HI/LO register pair.
//  One bit per cycle: shift-add multiply, restoring divide. Signed
//  operations are run on magnitudes and the sign is applied on the edge
//  that enters DONE.
// Ports
//  clk       clock
//  rst       synchronous active-high reset
//  srcA      operand A (multiplier / dividend / MTHI-MTLO data)
//  srcB      operand B (multiplicand / divisor)
//  startMul  start a multiply (ignored while running)
//  startDiv  start a divide (ignored while running)
//  signedOp  treat the started operation as signed
//  writeHi   MTHI request, ignored while running
//  writeLo   MTLO request, ignored while running
//  hi, lo    HI/LO registers
//  busy      iteration in progress
//  done      one-cycle pulse after HI/LO were written by a multiply/divide
module sm_alu_mdu_core
    import sm_alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             startMul,
    input  logic             startDiv,
    input  logic             signedOp,
    input  logic             writeHi,
    input  logic             writeLo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    mduState_t        state;
    mduState_t        stateNext;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   accReg;
    logic [WIDTH-1:0] lowReg;
    logic [WIDTH-1:0] opReg;
    logic             isDiv;
    logic             negMain;
    logic             negRem;

    logic             startAny;
    logic             accept;
    logic             signA;
    logic             signB;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;

    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   divTrial;
    logic             divOk;
    logic [WIDTH:0]   stepAcc;
    logic [WIDTH-1:0] stepLow;

    logic [2*WIDTH-1:0] prodRaw;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix;
    logic [WIDTH-1:0]   remFix;
    logic [WIDTH-1:0]   hiFinal;
    logic [WIDTH-1:0]   loFinal;

    assign startAny = startMul | startDiv;
    assign accept   = startAny && (state != MDU_RUN);

    // Operand magnitudes. The unsigned engine sees |a| and |b|; the signs are
    // remembered so the result can be corrected at the end. |MIN| is MIN
    // reinterpreted as unsigned, which is exactly the magnitude we need.
    always_comb begin
        signA = signedOp & srcA[WIDTH-1];
        signB = signedOp & srcB[WIDTH-1];
        magA  = signA ? (-srcA) : srcA;
        magB  = signB ? (-srcB) : srcB;
    end

    // One iteration of either algorithm. For a multiply, {accReg, lowReg}
    // is the running product with the multiplier shifting out of lowReg.
    // For a divide, accReg is the partial remainder and lowReg shifts the
    // dividend out at the top while quotient bits enter at the bottom.
    // A zero divisor makes every trial succeed, which leaves the dividend
    // as remainder and an all-ones quotient without any special casing.
    always_comb begin
        mulSum   = accReg + (lowReg[0] ? {1'b0, opReg} : {(WIDTH+1){1'b0}});
        divShift = {accReg[WIDTH-1:0], lowReg[WIDTH-1]};
        divTrial = divShift - {1'b0, opReg};
        divOk    = ~divTrial[WIDTH];
        if (isDiv) begin
            stepAcc = divOk ? divTrial : divShift;
            stepLow = {lowReg[WIDTH-2:0], divOk};
        end else begin
            stepAcc = {1'b0, mulSum[WIDTH:1]};
            stepLow = {mulSum[0], lowReg[WIDTH-1:1]};
        end
    end

    // Sign fix-up applied to the values produced by the last iteration.
    // Product and quotient flip when operand signs differ; the remainder
    // follows the dividend.
    always_comb begin
        prodRaw = {stepAcc[WIDTH-1:0], stepLow};
        prodFix = negMain ? (-prodRaw) : prodRaw;
        quotFix = negMain ? (-stepLow) : stepLow;
        remFix  = negRem ? (-stepAcc[WIDTH-1:0]) : stepAcc[WIDTH-1:0];
        if (isDiv) begin
            hiFinal = remFix;
            loFinal = quotFix;
        end else begin
            hiFinal = prodFix[2*WIDTH-1:WIDTH];
            loFinal = prodFix[WIDTH-1:0];
        end
    end

    // State register; reset always returns to IDLE, which also aborts any
    // operation in flight without producing a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MDU_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and status outputs. DONE lasts one cycle but can accept a
    // new start directly so back-to-back operations lose no cycle.
    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            MDU_IDLE: begin
                if (startAny) begin
                    stateNext = MDU_RUN;
                end
            end
            MDU_RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    stateNext = MDU_DONE;
                end
            end
            MDU_DONE: begin
                done = 1'b1;
                if (startAny) begin
                    stateNext = MDU_RUN;
                end else begin
                    stateNext = MDU_IDLE;
                end
            end
            default: begin
                stateNext = MDU_IDLE;
            end
        endcase
    end

    // Datapath registers. A start outside RUN latches the operands and
    // loads the iteration counter; each RUN cycle performs one iteration
    // and the final one (counter at zero) writes HI/LO. MTHI/MTLO share the
    // same "not running" condition so a busy unit is never disturbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            accReg  <= '0;
            lowReg  <= '0;
            opReg   <= '0;
            isDiv   <= 1'b0;
            negMain <= 1'b0;
            negRem  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (accept) begin
                cnt     <= CW'(WIDTH - 1);
                accReg  <= '0;
                lowReg  <= magA;
                opReg   <= magB;
                isDiv   <= startDiv;
                negMain <= signA ^ signB;
                negRem  <= signA;
            end else if (state == MDU_RUN) begin
                accReg <= stepAcc;
                lowReg <= stepLow;
                if (cnt == '0) begin
                    hi <= hiFinal;
                    lo <= loFinal;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
            if (writeHi && (state != MDU_RUN)) begin
                hi <= srcA;
            end
            if (writeLo && (state != MDU_RUN)) begin
                lo <= srcA;
            end
        end
    end

endmodule

// File: rtl/sm_alu_mdu.sv
// sm_alu_mdu
//  schoolMIPS execute-stage ALU: single-cycle combinational operations plus
//  an iterative multiply/divide unit with HI/LO (sm_alu_mdu_core).
//  Build option: define SM_MDU_SIGNED_EN to accept ALU_MULT/ALU_DIV as
//  signed multiply/divide; without it those codes act as unknown codes.
// Ports
//  clk       clock
//  rst       synchronous active-high reset
//  srcA      operand A (rs)
//  srcB      operand B (rt / immediate)
//  oper      ALU_* operation code
//  shift     shift amount for SLL/SRL
//  start     execute enable for HI/LO-writing operations
//  result    combinational result
//  zero      result == 0
//  busy      multiply/divide iterating
//  done      one-cycle pulse when a multiply/divide updated HI/LO
//  md_stall  HI/LO operation presented while the unit is busy
module sm_alu_mdu
    import sm_alu_mdu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [4:0]       oper,
    input  logic [SHW-1:0]   shift,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             md_stall
);

`ifdef SM_MDU_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             startMul;
    logic             startDiv;
    logic             signedOp;
    logic             writeHi;
    logic             writeLo;

    // Decode of the operations that hand work to the multiply/divide unit.
    // The signed codes are only recognised when the signed engine is built.
    always_comb begin
        signedOp = SIGNED_EN && ((oper == ALU_MULT) || (oper == ALU_DIV));
        startMul = start && ((oper == ALU_MULTU) || (SIGNED_EN && (oper == ALU_MULT)));
        startDiv = start && ((oper == ALU_DIVU) || (SIGNED_EN && (oper == ALU_DIV)));
        writeHi  = start && (oper == ALU_MTHI);
        writeLo  = start && (oper == ALU_MTLO);
    end

    sm_alu_mdu_core #(
        .WIDTH (WIDTH)
    ) mdu (
        .clk      (clk),
        .rst      (rst),
        .srcA     (srcA),
        .srcB     (srcB),
        .startMul (startMul),
        .startDiv (startDiv),
        .signedOp (signedOp),
        .writeHi  (writeHi),
        .writeLo  (writeLo),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done)
    );

    // Combinational result mux. Anything not listed, including the
    // HI/LO-writing codes, falls back to an addition so the datapath never
    // produces an undefined value.
    always_comb begin
        result = srcA + srcB;
        case (oper)
            ALU_ADD:  result = srcA + srcB;
            ALU_OR:   result = srcA | srcB;
            ALU_AND:  result = srcA & srcB;
            ALU_XOR:  result = srcA ^ srcB;
            ALU_NOR:  result = ~(srcA | srcB);
            ALU_SUBU: result = srcA - srcB;
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
            ALU_SRL:  result = srcB >> shift;
            ALU_SLL:  result = srcB << shift;
            ALU_LUI:  result = srcB << (WIDTH / 2);
            ALU_MFHI: result = hi;
            ALU_MFLO: result = lo;
            default:  result = srcA + srcB;
        endcase
    end

    // The stall covers reads of HI/LO (which would otherwise return stale
    // data) and new starts (which the busy unit would silently drop).
    always_comb begin
        zero     = (result == '0);
        md_stall = busy && isHiLoOp(oper, SIGNED_EN);
    end

endmodule

// File: tb/tb_sm_alu_mdu.sv
// tb_sm_alu_mdu
//  Self-checking bench for sm_alu_mdu at WIDTH=32: table of combinational
//  vectors followed by hand-written multiply/divide sequences.
//  Signed cases are exercised when SM_MDU_SIGNED_EN is defined.
module tb_sm_alu_mdu;
    import sm_alu_mdu_pkg::*;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic [4:0]       oper;
    logic [SHW-1:0]   shift;
    logic             start;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;
    logic             mdStall;

    int checksTotal  = 0;
    int checksPassed = 0;

    typedef struct {
        logic [4:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SHW-1:0]   sh;
        logic [WIDTH-1:0] expResult;
        logic             expZero;
        string            name;
    } vec_t;

    sm_alu_mdu #(
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .srcA     (srcA),
        .srcB     (srcB),
        .oper     (oper),
        .shift    (shift),
        .start    (start),
        .result   (result),
        .zero     (zero),
        .busy     (busy),
        .done     (done),
        .md_stall (mdStall)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic [SHW-1:0] sh,
                                 input logic st);
        oper  = op;
        srcA  = a;
        srcB  = b;
        shift = sh;
        start = st;
        #1;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic readHiLo(input string name, input logic [WIDTH-1:0] expHi,
                            input logic [WIDTH-1:0] expLo);
        applyStimulus(ALU_MFHI, '0, '0, '0, 1'b0);
        checkOutput({name, " hi"}, result, expHi);
        applyStimulus(ALU_MFLO, '0, '0, '0, 1'b0);
        checkOutput({name, " lo"}, result, expLo);
    endtask

    // Presents a start for exactly one edge (edge 0); returns just after it.
    task automatic startOp(input logic [4:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
        applyStimulus(op, a, b, '0, 1'b1);
        nextEdge();
        applyStimulus(ALU_ADD, '0, '0, '0, 1'b0);
    endtask

    // Called just after edge 0; counts busy cycles and reports the index of
    // the edge after which done is seen (-1 if it never appears).
    task automatic waitDone(output int busyCycles, output int doneEdge);
        busyCycles = 0;
        doneEdge   = -1;
        for (int e = 0; e < 100; e++) begin
            if (busy) busyCycles++;
            if (done) begin
                doneEdge = e;
                break;
            end
            nextEdge();
        end
    endtask

    // Full multiply/divide with latency and HI/LO checks; ends one cycle
    // after the done cycle, checking that done was a single pulse.
    task automatic runMdu(input string name, input logic [4:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] expHi, input logic [WIDTH-1:0] expLo);
        int bc;
        int de;
        startOp(op, a, b);
        waitDone(bc, de);
        checkOutput({name, " busy cycles"}, WIDTH'(bc), WIDTH'(WIDTH));
        checkOutput({name, " done edge"}, WIDTH'(de), WIDTH'(WIDTH));
        readHiLo(name, expHi, expLo);
        nextEdge();
        checkOutput({name, " done pulse ends"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        vec_t vectors[13];
        int   bc;
        int   de;
        int   donePulses;

        vectors[0]  = '{ALU_ADD,  32'd5,          32'd7,          5'd0,  32'd12,         1'b0, "ADD 5+7"};
        vectors[1]  = '{ALU_SUBU, 32'd9,          32'd9,          5'd0,  32'd0,          1'b1, "SUBU 9-9"};
        vectors[2]  = '{ALU_SRL,  32'd0,          32'h8000_0000,  5'd31, 32'd1,          1'b0, "SRL 31"};
        vectors[3]  = '{ALU_NOR,  32'd0,          32'd0,          5'd0,  32'hFFFF_FFFF,  1'b0, "NOR 0,0"};
        vectors[4]  = '{ALU_LUI,  32'd0,          32'h0000_1234,  5'd0,  32'h1234_0000,  1'b0, "LUI"};
        vectors[5]  = '{ALU_OR,   32'h0000_00F0,  32'h0000_000F,  5'd0,  32'h0000_00FF,  1'b0, "OR"};
        vectors[6]  = '{ALU_AND,  32'hFF00_FF00,  32'h0FF0_0FF0,  5'd0,  32'h0F00_0F00,  1'b0, "AND"};
        vectors[7]  = '{ALU_XOR,  32'hAAAA_5555,  32'hFFFF_0000,  5'd0,  32'h5555_5555,  1'b0, "XOR"};
        vectors[8]  = '{ALU_SLTU, 32'd1,          32'd2,          5'd0,  32'd1,          1'b0, "SLTU 1<2"};
        vectors[9]  = '{ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b1, "SLTU big<1"};
        vectors[10] = '{ALU_SLL,  32'd0,          32'd1,          5'd31, 32'h8000_0000,  1'b0, "SLL 31"};
        vectors[11] = '{ALU_ADD,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b1, "ADD wrap"};
        vectors[12] = '{5'd31,    32'd3,          32'd4,          5'd0,  32'd7,          1'b0, "unknown op"};

        // Reset state.
        rst = 1'b1;
        applyStimulus(ALU_ADD, '0, '0, '0, 1'b0);
        nextEdge();
        nextEdge();
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset done", {31'b0, done}, 32'd0);
        readHiLo("reset", 32'd0, 32'd0);
        rst = 1'b0;
        nextEdge();

        // Combinational operations.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vectors[i].op, vectors[i].a, vectors[i].b, vectors[i].sh, 1'b0);
            checkOutput({vectors[i].name, " result"}, result, vectors[i].expResult);
            checkOutput({vectors[i].name, " zero"}, {31'b0, zero}, {31'b0, vectors[i].expZero});
        end

        // Full-range unsigned multiply.
        runMdu("MULTU max", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

        // Divide followed by a back-to-back start issued in the DONE cycle.
        startOp(ALU_DIVU, 32'd100, 32'd7);
        waitDone(bc, de);
        checkOutput("DIVU 100/7 done edge", WIDTH'(de), WIDTH'(WIDTH));
        readHiLo("DIVU 100/7", 32'd2, 32'd14);
        runMdu("DIVU 5/0 back-to-back", ALU_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);

        // Activity while running: start ignored, stale reads flagged.
        startOp(ALU_MULTU, 32'd3, 32'd4);
        for (int i = 0; i < 4; i++) nextEdge();
        applyStimulus(ALU_DIVU, 32'd100, 32'd7, '0, 1'b1);
        checkOutput("stall on DIVU start", {31'b0, mdStall}, 32'd1);
        nextEdge();
        applyStimulus(ALU_MFLO, '0, '0, '0, 1'b0);
        checkOutput("stall on MFLO", {31'b0, mdStall}, 32'd1);
        checkOutput("MFLO old value", result, 32'hFFFF_FFFF);
        applyStimulus(ALU_ADD, 32'd1, 32'd2, '0, 1'b0);
        checkOutput("no stall on ADD", {31'b0, mdStall}, 32'd0);
        checkOutput("ADD during RUN", result, 32'd3);
        waitDone(bc, de);
        checkOutput("MULTU 3*4 reached done", {31'b0, (de >= 0)}, 32'd1);
        readHiLo("MULTU 3*4 (DIVU ignored)", 32'd0, 32'd12);
        nextEdge();

        // MTLO/MTHI while idle.
        applyStimulus(ALU_MTLO, 32'h0000_1234, '0, '0, 1'b1);
        nextEdge();
        applyStimulus(ALU_MTHI, 32'h0000_ABCD, '0, '0, 1'b1);
        nextEdge();
        readHiLo("MTHI/MTLO", 32'h0000_ABCD, 32'h0000_1234);

        // Reset in the middle of an iteration.
        startOp(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 9; i++) nextEdge();
        checkOutput("busy before abort", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        nextEdge();
        checkOutput("abort busy", {31'b0, busy}, 32'd0);
        readHiLo("abort", 32'd0, 32'd0);
        rst = 1'b0;
        donePulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) donePulses++;
            nextEdge();
        end
        checkOutput("no done after abort", WIDTH'(donePulses), 32'd0);
        runMdu("MULTU 6*7 after abort", ALU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

`ifdef SM_MDU_SIGNED_EN
        runMdu("MULT -3*5", ALU_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        runMdu("DIV -7/2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runMdu("DIV -8/0", ALU_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'd1);
        runMdu("DIV MIN/-1", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
`else
        applyStimulus(ALU_MULT, 32'd10, 32'd20, '0, 1'b1);
        checkOutput("MULT as unknown result", result, 32'd30);
        nextEdge();
        applyStimulus(ALU_ADD, '0, '0, '0, 1'b0);
        checkOutput("MULT as unknown busy", {31'b0, busy}, 32'd0);
        nextEdge();
        checkOutput("MULT as unknown no done", {31'b0, done}, 32'd0);
        readHiLo("MULT as unknown", 32'd0, 32'd42);
`endif

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
